// File: rtl/score_engine.sv
// Multi-lane pattern scorer: per-lane decaying targets matched by player writes,
// with expiry/replacement misses, a combo multiplier and a saturating score.
module score_engine #(
  parameter int NUM_CH    = 4,
  parameter int PAT_W     = 8,
  parameter int SCORE_W   = 11,
  parameter int PTS_W     = 4,
  parameter int MAX_PTS   = 10,
  parameter int COMBO_EN  = 1,
  parameter int COMBO_MAX = 4,
  parameter int PENALTY   = 0,
  localparam int ADDR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      CLOCK50M,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic [NUM_CH*PAT_W-1:0]   pattern_in,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [PAT_W-1:0]          user_input,
  output logic [SCORE_W-1:0]        score_out,
  output logic [NUM_CH*PAT_W-1:0]   pattern_out,
  output logic [NUM_CH-1:0]         active_out,
  output logic [2:0]                combo_out,
  output logic [7:0]                miss_count,
  output logic                      hit_pulse,
  output logic                      miss_pulse
);

  localparam int AWARD_W = PTS_W + 3;
  localparam int SUM_W   = ((SCORE_W > AWARD_W) ? SCORE_W : AWARD_W) + 1;

  logic [NUM_CH*PAT_W-1:0] pat_bus;
  logic [NUM_CH*PTS_W-1:0] pts_bus;
  logic [NUM_CH-1:0]       act_bus;
  logic [NUM_CH-1:0]       lane_sel;
  logic [NUM_CH-1:0]       miss_vec;

  logic [PAT_W-1:0]   sel_pat;
  logic [PTS_W-1:0]   sel_pts;
  logic               wr_valid;
  logic               is_hit;
  logic               is_wrong;
  logic [3:0]         n_miss;
  logic               any_miss;

  logic [SCORE_W-1:0] score_reg, score_next;
  logic [2:0]         combo_reg, combo_next;
  logic [7:0]         miss_reg, miss_next;
  logic               hit_pulse_reg, miss_pulse_reg;

  logic [AWARD_W-1:0] mult;
  logic [AWARD_W-1:0] award;
  logic [SUM_W-1:0]   score_sum;
  logic [8:0]         miss_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [PAT_W-1:0] pat_reg, pat_next, lane_in;
      logic [PTS_W-1:0] pts_reg, pts_next;
      logic             act_reg, act_next, lane_miss;

      assign lane_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));
      assign lane_in      = pattern_in[gi*PAT_W +: PAT_W];

      // A valid write to this lane takes precedence over its tick handling.
      always_comb begin
        pat_next  = pat_reg;
        pts_next  = pts_reg;
        act_next  = act_reg;
        lane_miss = 1'b0;
        if (wr_valid && lane_sel[gi]) begin
          if (is_hit) begin
            pat_next = '0;
            pts_next = '0;
            act_next = 1'b0;
          end
        end else if (tick) begin
          if ((lane_in != '0) && (lane_in != pat_reg)) begin
            pat_next  = lane_in;
            pts_next  = PTS_W'(MAX_PTS);
            act_next  = 1'b1;
            lane_miss = act_reg;
          end else if (act_reg) begin
            if (pts_reg > PTS_W'(1)) begin
              pts_next = pts_reg - PTS_W'(1);
            end else begin
              pat_next  = '0;
              pts_next  = '0;
              act_next  = 1'b0;
              lane_miss = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge CLOCK50M or negedge reset_n) begin
        if (!reset_n) begin
          pat_reg <= '0;
          pts_reg <= '0;
          act_reg <= 1'b0;
        end else begin
          pat_reg <= pat_next;
          pts_reg <= pts_next;
          act_reg <= act_next;
        end
      end

      assign pat_bus[gi*PAT_W +: PAT_W] = pat_reg;
      assign pts_bus[gi*PTS_W +: PTS_W] = pts_reg;
      assign act_bus[gi]                = act_reg;
      assign miss_vec[gi]               = lane_miss;
    end
  endgenerate

  // Pattern/points of the addressed lane; zero when the address is out of range.
  always_comb begin
    sel_pat = '0;
    sel_pts = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane_sel[i]) begin
        sel_pat = pat_bus[i*PAT_W +: PAT_W];
        sel_pts = pts_bus[i*PTS_W +: PTS_W];
      end
    end
  end

  assign wr_valid = (|(lane_sel & act_bus)) && (user_input != '0);
  assign is_hit   = wr_valid && (user_input == sel_pat);
  assign is_wrong = wr_valid && (user_input != sel_pat);

  always_comb begin
    n_miss = {3'b000, is_wrong};
    for (int i = 0; i < NUM_CH; i++) begin
      n_miss = n_miss + {3'b000, miss_vec[i]};
    end
  end
  assign any_miss = (n_miss != 4'd0);

  assign mult      = (COMBO_EN != 0) ? AWARD_W'(combo_reg) : AWARD_W'(1);
  assign award     = AWARD_W'(sel_pts) * mult;
  assign score_sum = SUM_W'(score_reg) + SUM_W'(award);
  assign miss_sum  = {1'b0, miss_reg} + 9'(n_miss);

  always_comb begin
    score_next = score_reg;
    if (is_hit) begin
      if (score_sum > SUM_W'({SCORE_W{1'b1}})) begin
        score_next = {SCORE_W{1'b1}};
      end else begin
        score_next = score_sum[SCORE_W-1:0];
      end
    end else if (is_wrong) begin
      if (SUM_W'(score_reg) >= SUM_W'(PENALTY)) begin
        score_next = score_reg - SCORE_W'(PENALTY);
      end else begin
        score_next = '0;
      end
    end
  end

  // Any miss in the cycle wins over a hit's combo increment.
  always_comb begin
    combo_next = combo_reg;
    if (any_miss) begin
      combo_next = 3'd1;
    end else if (is_hit && (combo_reg < 3'(COMBO_MAX))) begin
      combo_next = combo_reg + 3'd1;
    end
  end

  assign miss_next = (miss_sum > 9'd255) ? 8'd255 : miss_sum[7:0];

  always_ff @(posedge CLOCK50M or negedge reset_n) begin
    if (!reset_n) begin
      score_reg      <= '0;
      combo_reg      <= 3'd1;
      miss_reg       <= '0;
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
    end else begin
      score_reg      <= score_next;
      combo_reg      <= combo_next;
      miss_reg       <= miss_next;
      hit_pulse_reg  <= is_hit;
      miss_pulse_reg <= any_miss;
    end
  end

  assign score_out   = score_reg;
  assign pattern_out = pat_bus;
  assign active_out  = act_bus;
  assign combo_out   = combo_reg;
  assign miss_count  = miss_reg;
  assign hit_pulse   = hit_pulse_reg;
  assign miss_pulse  = miss_pulse_reg;

endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine: a rule-level model predicts every output each cycle.
module tb_score_engine;

  localparam int NUM_CH    = 5;
  localparam int PAT_W     = 8;
  localparam int SCORE_W   = 11;
  localparam int PTS_W     = 4;
  localparam int MAX_PTS   = 10;
  localparam int COMBO_EN  = 1;
  localparam int COMBO_MAX = 4;
  localparam int PENALTY   = 3;
  localparam int ADDR_W    = 3;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic                    CLOCK50M = 1'b0;
  logic                    reset_n;
  logic                    tick;
  logic [NUM_CH*PAT_W-1:0] pattern_in;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [PAT_W-1:0]        user_input;
  logic [SCORE_W-1:0]      score_out;
  logic [NUM_CH*PAT_W-1:0] pattern_out;
  logic [NUM_CH-1:0]       active_out;
  logic [2:0]              combo_out;
  logic [7:0]              miss_count;
  logic                    hit_pulse;
  logic                    miss_pulse;

  logic [PAT_W-1:0] pin [NUM_CH];

  int m_pat [NUM_CH];
  int m_pts [NUM_CH];
  int m_score, m_combo, m_miss;
  bit m_hit, m_mp;

  int tests = 0;
  int fails = 0;
  int snap_score, snap_miss;

  score_engine #(
    .NUM_CH(NUM_CH), .PAT_W(PAT_W), .SCORE_W(SCORE_W), .PTS_W(PTS_W),
    .MAX_PTS(MAX_PTS), .COMBO_EN(COMBO_EN), .COMBO_MAX(COMBO_MAX), .PENALTY(PENALTY)
  ) dut (
    .CLOCK50M(CLOCK50M), .reset_n(reset_n), .tick(tick), .pattern_in(pattern_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .user_input(user_input),
    .score_out(score_out), .pattern_out(pattern_out), .active_out(active_out),
    .combo_out(combo_out), .miss_count(miss_count), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse)
  );

  always #10 CLOCK50M = ~CLOCK50M;

  always_comb begin
    pattern_in = '0;
    for (int i = 0; i < NUM_CH; i++) pattern_in[i*PAT_W +: PAT_W] = pin[i];
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pat[i] = 0;
      m_pts[i] = 0;
    end
    m_score = 0; m_combo = 1; m_miss = 0; m_hit = 0; m_mp = 0;
  endtask

  // Game rules: a lane is live exactly when it holds a nonzero pattern.
  task automatic model_step(input bit tk, input bit we, input int a, input int ui);
    int  misses;
    bit  valid, hit;
    int  award, p;
    misses = 0;
    hit    = 0;
    valid  = we && (a < NUM_CH) && (ui != 0);
    if (valid) valid = (m_pat[a] != 0);
    if (valid) begin
      if (ui == m_pat[a]) begin
        hit   = 1;
        award = m_pts[a] * ((COMBO_EN != 0) ? m_combo : 1);
        m_score = (m_score + award > SCORE_MAX) ? SCORE_MAX : m_score + award;
        m_pat[a] = 0;
        m_pts[a] = 0;
      end else begin
        misses++;
        m_score = (m_score > PENALTY) ? m_score - PENALTY : 0;
      end
    end
    if (tk) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (valid && i == a) continue;
        p = int'(pin[i]);
        if (p != 0 && p != m_pat[i]) begin
          if (m_pat[i] != 0) misses++;
          m_pat[i] = p;
          m_pts[i] = MAX_PTS;
        end else if (m_pat[i] != 0) begin
          if (m_pts[i] > 1) m_pts[i]--;
          else begin
            m_pat[i] = 0;
            m_pts[i] = 0;
            misses++;
          end
        end
      end
    end
    m_miss = (m_miss + misses > 255) ? 255 : m_miss + misses;
    if (misses > 0) m_combo = 1;
    else if (hit && m_combo < COMBO_MAX) m_combo++;
    m_hit = hit;
    m_mp  = (misses > 0);
  endtask

  task automatic check_all();
    chk("score", int'(score_out), m_score);
    chk("combo", int'(combo_out), m_combo);
    chk("miss_count", int'(miss_count), m_miss);
    chk("hit_pulse", int'(hit_pulse), int'(m_hit));
    chk("miss_pulse", int'(miss_pulse), int'(m_mp));
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("pattern%0d", i), int'(pattern_out[i*PAT_W +: PAT_W]), m_pat[i]);
      chk($sformatf("active%0d", i), int'(active_out[i]), int'(m_pat[i] != 0));
    end
  endtask

  task automatic cyc(input bit tk, input bit we, input int a, input logic [PAT_W-1:0] ui);
    tick       = tk;
    wr_en      = we;
    wr_addr    = a[ADDR_W-1:0];
    user_input = ui;
    model_step(tk, we, a, int'(ui));
    @(posedge CLOCK50M);
    #1;
    tick       = 1'b0;
    wr_en      = 1'b0;
    user_input = '0;
    check_all();
    $display("[TB] tick=%0d wr=%0d addr=%0d ui=%02h -> score=%0d combo=%0d miss=%0d act=%b hit=%0d mp=%0d",
             tk, we, a, ui, score_out, combo_out, miss_count, active_out, hit_pulse, miss_pulse);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic clear_pins();
    for (int i = 0; i < NUM_CH; i++) pin[i] = '0;
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; wr_en = 1'b0; wr_addr = '0; user_input = '0;
    clear_pins();
    model_reset();
    repeat (2) @(posedge CLOCK50M);
    #1;
    check_all();
    reset_n = 1'b1;

    // First load and hit on lane 0
    pin[0] = 8'h3C;
    ticks(1);
    chk("lit_lane0_load", int'(pattern_out[7:0]), 8'h3C);
    chk("lit_active_load", int'(active_out), 5'b00001);
    pin[0] = 8'h00;
    cyc(1'b0, 1'b1, 0, 8'h3C);
    chk("lit_first_score", int'(score_out), 10);
    chk("lit_first_combo", int'(combo_out), 2);
    chk("lit_first_hit", int'(hit_pulse), 1);
    cyc(1'b0, 1'b0, 0, 8'h00);
    chk("lit_hit_drop", int'(hit_pulse), 0);

    // Decayed hit, then combo build-up to saturation
    pin[1] = 8'h55;
    ticks(1);
    pin[1] = 8'h00;
    ticks(3);
    cyc(1'b0, 1'b1, 1, 8'h55);
    chk("lit_decay_award", int'(score_out), 24);
    pin[2] = 8'hAA;
    ticks(1);
    pin[2] = 8'h00;
    cyc(1'b0, 1'b1, 2, 8'hAA);
    chk("lit_combo3_score", int'(score_out), 54);
    pin[0] = 8'h11;
    ticks(1);
    pin[0] = 8'h00;
    cyc(1'b0, 1'b1, 0, 8'h11);
    chk("lit_combo_sat", int'(combo_out), 4);
    chk("lit_combo4_score", int'(score_out), 94);

    // Expiry after ten unattended ticks
    pin[3] = 8'hA1;
    ticks(1);
    pin[3] = 8'h00;
    ticks(9);
    chk("lit_not_expired", int'(active_out[3]), 1);
    ticks(1);
    chk("lit_expire_miss", int'(miss_count), 1);
    chk("lit_expire_combo", int'(combo_out), 1);
    chk("lit_expire_score", int'(score_out), 94);
    chk("lit_expire_pulse", int'(miss_pulse), 1);

    // Drive the score into its ceiling
    for (int k = 0; k < 60; k++) begin
      pin[0] = 8'h77;
      ticks(1);
      pin[0] = 8'h00;
      cyc(1'b0, 1'b1, 0, 8'h77);
    end
    chk("lit_score_clamp", int'(score_out), SCORE_MAX);

    // Asynchronous reset mid-game
    pin[2] = 8'h42;
    ticks(1);
    pin[2] = 8'h00;
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("lit_async_score", int'(score_out), 0);
    chk("lit_async_active", int'(active_out), 0);
    chk("lit_async_combo", int'(combo_out), 1);
    @(posedge CLOCK50M);
    #1;
    reset_n = 1'b1;

    // Penalty clamps at zero; wrong input keeps the lane live
    pin[0] = 8'h3C;
    ticks(1);
    pin[0] = 8'h00;
    ticks(8);
    cyc(1'b0, 1'b1, 0, 8'h3C);
    chk("lit_score_two", int'(score_out), 2);
    pin[1] = 8'hFE;
    ticks(1);
    pin[1] = 8'h00;
    cyc(1'b0, 1'b1, 1, 8'hFF);
    chk("lit_penalty_floor", int'(score_out), 0);
    chk("lit_penalty_miss", int'(miss_count), 1);
    chk("lit_penalty_live", int'(active_out), 5'b00010);
    cyc(1'b0, 1'b1, 2, 8'h12);
    cyc(1'b0, 1'b1, 6, 8'hFE);
    cyc(1'b0, 1'b1, 1, 8'h00);
    chk("lit_ignored_miss", int'(miss_count), 1);
    chk("lit_ignored_active", int'(active_out), 5'b00010);

    // Hit and double expiry in one cycle
    pin[1] = 8'h21; pin[2] = 8'h22; pin[3] = 8'h33; pin[4] = 8'h44;
    ticks(1);
    clear_pins();
    cyc(1'b0, 1'b1, 3, 8'h33);
    cyc(1'b0, 1'b1, 4, 8'h44);
    ticks(8);
    pin[0] = 8'h3C;
    ticks(1);
    chk("lit_pre_combo", int'(combo_out), 3);
    snap_score = int'(score_out);
    snap_miss  = int'(miss_count);
    pin[0] = 8'h5A;
    cyc(1'b1, 1'b1, 0, 8'h3C);
    pin[0] = 8'h00;
    chk("lit_same_score", int'(score_out), snap_score + 30);
    chk("lit_same_miss", int'(miss_count), snap_miss + 2);
    chk("lit_same_combo", int'(combo_out), 1);
    chk("lit_same_hit", int'(hit_pulse), 1);
    chk("lit_same_mpulse", int'(miss_pulse), 1);
    chk("lit_no_reload", int'(pattern_out[7:0]), 0);

    // Miss counter saturation
    pin[1] = 8'hFE;
    ticks(1);
    pin[1] = 8'h00;
    for (int k = 0; k < 260; k++) cyc(1'b0, 1'b1, 1, 8'hFF);
    chk("lit_miss_sat", int'(miss_count), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
